// File: rtl/sample_feeder.sv
// ============================================================================
// Module      : sample_feeder
// Description : Sample FIFO with a four-phase req/ack responder that feeds the
//               resampling filter from a fixed-rate sample source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_feeder #(
    parameter int DWIDTH    = 16,
    parameter int DEPTH     = 8,
    parameter int DEPTH_LOG = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [0:DWIDTH-1]    sample_in,
    input  logic                 sample_valid,
    input  logic                 req,
    output logic                 ack,
    output logic [0:DWIDTH-1]    data_out,
    output logic [DEPTH_LOG:0]   level,
    output logic                 overflow,
    output logic                 starved
);

    localparam logic [DEPTH_LOG:0]   c_FULL    = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0]   c_LVL_ONE = (DEPTH_LOG + 1)'(1);
    localparam logic [DEPTH_LOG-1:0] c_PTR_ONE = DEPTH_LOG'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [0:DWIDTH-1]     r_mem [DEPTH];
    logic [DEPTH_LOG-1:0]  r_wr_ptr;
    logic [DEPTH_LOG-1:0]  r_rd_ptr;
    logic [DEPTH_LOG:0]    r_level;
    logic                  r_ack;
    logic                  r_overflow;
    logic                  r_starved;
    logic [0:DWIDTH-1]     r_data;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ack_nxt;
    logic                  w_starved_nxt;
    logic [0:DWIDTH-1]     w_data_nxt;

    assign w_full  = (r_level == c_FULL);
    assign w_empty = (r_level == '0);
    assign w_push  = sample_valid && !w_full;

    // The head entry stays counted in level until the handshake completes.
    always_comb begin
        w_state_nxt   = r_state;
        w_ack_nxt     = r_ack;
        w_data_nxt    = r_data;
        w_starved_nxt = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ack_nxt = 1'b0;
                if (req) begin
                    if (!w_empty) begin
                        w_data_nxt  = r_mem[r_rd_ptr];
                        w_ack_nxt   = 1'b1;
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_starved_nxt = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                if (!req) begin
                    w_ack_nxt   = 1'b0;
                    w_pop       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_ack_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ack      <= 1'b0;
            r_data     <= '0;
            r_starved  <= 1'b0;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ack     <= w_ack_nxt;
            r_data    <= w_data_nxt;
            r_starved <= w_starved_nxt;
            if (sample_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    assign ack      = r_ack;
    assign data_out = r_data;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign starved  = r_starved;

endmodule

`default_nettype wire

// File: tb/tb_sample_feeder.sv
// ============================================================================
// Module      : tb_sample_feeder
// Description : Self-checking bench for sample_feeder: directed scenarios plus
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sample_feeder;

    localparam int c_DW    = 16;
    localparam int c_DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [c_DW-1:0]   sample_in = '0;
    logic              sample_valid = 1'b0;
    logic              req = 1'b0;
    logic              ack;
    logic [c_DW-1:0]   data_out;
    logic [3:0]        level;
    logic              overflow;
    logic              starved;

    int n_cmp = 0;
    int n_err = 0;

    sample_feeder #(.DWIDTH(c_DW), .DEPTH(c_DEPTH), .DEPTH_LOG(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .req          (req),
        .ack          (ack),
        .data_out     (data_out),
        .level        (level),
        .overflow     (overflow),
        .starved      (starved)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: the FIFO is a queue; the responder is "is a sample under ack".
    logic [c_DW-1:0] mq[$];
    bit              m_ack;
    logic [c_DW-1:0] m_data;
    bit              m_ovf;
    bit              m_starved;
    int              m_sz;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ack     = 1'b0;
            m_data    = '0;
            m_ovf     = 1'b0;
            m_starved = 1'b0;
        end else begin
            m_sz      = mq.size();
            m_starved = !m_ack && req && (m_sz == 0);
            if (sample_valid) begin
                if (m_sz == c_DEPTH) m_ovf = 1'b1;
                else                 mq.push_back(sample_in);
            end
            if (m_ack && !req) begin
                void'(mq.pop_front());
                m_ack = 1'b0;
            end else if (!m_ack && req && m_sz > 0) begin
                m_ack  = 1'b1;
                m_data = mq[0];
            end
        end
        #1;
        check("model_ack",      32'(ack),      32'(m_ack));
        check("model_data",     32'(data_out), 32'(m_data));
        check("model_level",    32'(level),    32'(mq.size()));
        check("model_overflow", 32'(overflow), 32'(m_ovf));
        check("model_starved",  32'(starved),  32'(m_starved));
    end

    // All stimulus changes on the falling edge.
    task automatic push(input logic [c_DW-1:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input logic val, input string tag);
        int cnt = 0;
        while (ack !== val && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (ack !== val) check({tag, "_timeout"}, 32'(ack), 32'(val));
    endtask

    task automatic handshake(input logic [c_DW-1:0] exp, input string tag);
        req = 1'b1;
        @(negedge clk);
        wait_ack(1'b1, tag);
        check(tag, 32'(data_out), 32'(exp));
        req = 1'b0;
        @(negedge clk);
        wait_ack(1'b0, tag);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ack",   32'(ack),   32'd0);
        check("reset_level", 32'(level), 32'd0);

        // Single sample handshake
        push(16'h1234);
        req = 1'b1;
        @(negedge clk);
        check("t1_ack",  32'(ack),      32'd1);
        check("t1_data", 32'(data_out), 32'h1234);
        check("t1_lvl",  32'(level),    32'd1);
        req = 1'b0;
        @(negedge clk);
        check("t1_ack_rel", 32'(ack),   32'd0);
        check("t1_lvl_rel", 32'(level), 32'd0);

        // Starvation then late sample
        do_reset();
        req = 1'b1;
        repeat (10) @(negedge clk);
        check("t2_starved", 32'(starved), 32'd1);
        check("t2_ack0",    32'(ack),     32'd0);
        push(16'hFFFF);
        check("t2_ack_early", 32'(ack), 32'd0);
        @(negedge clk);
        check("t2_ack",       32'(ack),      32'd1);
        check("t2_data",      32'(data_out), 32'hFFFF);
        check("t2_starved0",  32'(starved),  32'd0);
        req = 1'b0;
        @(negedge clk);

        // Overflow then in-order drain
        do_reset();
        for (int i = 1; i <= 10; i++) push(16'(i));
        check("t3_level", 32'(level),    32'd8);
        check("t3_ovf",   32'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) handshake(16'(i), "t3_order");
        check("t3_empty", 32'(level), 32'd0);

        // Push on the pop edge, across pointer wraparound
        do_reset();
        for (int i = 0; i < 3; i++) push(16'h7000 + 16'(i));
        for (int i = 0; i < 20; i++) begin
            req = 1'b1;
            @(negedge clk);
            wait_ack(1'b1, "t4");
            req = 1'b0;
            push(16'h8000 + 16'(i));
            check("t4_level", 32'(level), 32'd3);
        end

        // Reset mid-handshake
        do_reset();
        for (int i = 0; i < 5; i++) push(16'hA000 + 16'(i));
        req = 1'b1;
        @(negedge clk);
        check("t5_ack1",  32'(ack),   32'd1);
        check("t5_lvl5",  32'(level), 32'd5);
        do_reset();
        check("t5_ack0",  32'(ack),      32'd0);
        check("t5_lvl0",  32'(level),    32'd0);
        check("t5_ovf0",  32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        check("t5_held_ack", 32'(ack),     32'd0);
        check("t5_starved",  32'(starved), 32'd1);
        push(16'h5A5A);
        @(negedge clk);
        check("t5_served", 32'(ack),      32'd1);
        check("t5_data",   32'(data_out), 32'h5A5A);
        req = 1'b0;
        @(negedge clk);

        // Randomized traffic: protocol-obeying filter, random-rate source
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            sample_in    = 16'($urandom);
            sample_valid = ($urandom_range(0, 99) < 45);
            if (!req && !ack && $urandom_range(0, 99) < 50)  req = 1'b1;
            else if (req && ack && $urandom_range(0, 99) < 60) req = 1'b0;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        req          = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
